// File: rtl/usb_rw_burst_ctrl.sv
// Host-side read/write burst controller for the USB memory-page link: per page it runs an
// address OUT transaction then a data IN/OUT transaction, retrying failed exchanges.
module usb_rw_burst_ctrl #(
    parameter int         DATA_BYTES = 8,
    parameter logic [6:0] ADDR       = 7'b1010000,
    parameter logic [3:0] ENDP_ADDR  = 4'b0010,
    parameter logic [3:0] ENDP_DATA  = 4'b0001,
    parameter int         MAX_RETRY  = 3,
    parameter int         BURST_W    = 4,
    localparam int        DW         = 8 * DATA_BYTES
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [1:0]         tsk,
    input  logic [15:0]        mempage,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [DW-1:0]      data_in,
    input  logic               data_in_valid,
    output logic               data_req,
    output logic [DW-1:0]      data_to_tb,
    output logic               data_avail,
    output logic [18:0]        token_pkt_out,
    output logic [8+DW-1:0]    data_pkt_out,
    output logic [1:0]         transaction,
    input  logic               ptcl_done,
    input  logic               ptcl_success,
    input  logic [DW-1:0]      ptcl_data,
    output logic               task_done,
    output logic               task_success,
    output logic [BURST_W-1:0] pages_done
);
    localparam logic [7:0] PID_OUT  = 8'b10000111;
    localparam logic [7:0] PID_IN   = 8'b10010110;
    localparam logic [7:0] PID_DATA = 8'b11000011;
    localparam int         RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WLOAD, S_DATA, S_RETRY, S_OK, S_FAIL
    } state_t;

    state_t             state, state_nxt;
    logic               is_read;
    logic               retry_data;
    logic [15:0]        base_page;
    logic [BURST_W-1:0] len_q;
    logic [BURST_W-1:0] k;
    logic [RW-1:0]      retry_cnt;
    logic [DW-1:0]      wbuf;
    logic [15:0]        page_addr;
    logic               last_page;
    logic               start;
    logic               retry_left;

    // Whole-vector bit reversal between natural order and wire order.
    function automatic logic [DW-1:0] rev(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = v[DW-1-i];
        return r;
    endfunction

    assign page_addr  = base_page + 16'(k);
    assign last_page  = ({1'b0, k} + 1'b1) == {1'b0, len_q};
    assign start      = (tsk == 2'b01) || (tsk == 2'b10);
    assign retry_left = retry_cnt != RW'(MAX_RETRY);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= S_IDLE;
            is_read    <= 1'b0;
            retry_data <= 1'b0;
            base_page  <= '0;
            len_q      <= '0;
            k          <= '0;
            retry_cnt  <= '0;
            wbuf       <= '0;
            data_to_tb <= '0;
            data_avail <= 1'b0;
            pages_done <= '0;
        end else begin
            state      <= state_nxt;
            data_avail <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    is_read   <= (tsk == 2'b01);
                    base_page <= mempage;
                    len_q     <= (burst_len == '0) ? BURST_W'(1) : burst_len;
                    k         <= '0;
                    retry_cnt <= '0;
                end
                S_ADDR, S_DATA: if (ptcl_done) begin
                    if (ptcl_success) begin
                        retry_cnt <= '0;
                        if (state == S_DATA) begin
                            pages_done <= pages_done + 1'b1;
                            if (is_read) begin
                                data_to_tb <= rev(ptcl_data);
                                data_avail <= 1'b1;
                            end
                            if (!last_page) k <= k + 1'b1;
                        end
                    end else begin
                        retry_data <= (state == S_DATA);
                    end
                end
                S_WLOAD: if (data_in_valid) wbuf <= data_in;
                S_RETRY: retry_cnt <= retry_cnt + 1'b1;
                S_OK, S_FAIL: if (tsk == 2'b00) begin
                    pages_done <= '0;
                    retry_cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        transaction   = 2'b00;
        token_pkt_out = '0;
        data_pkt_out  = '0;
        data_req      = 1'b0;
        task_done     = 1'b0;
        task_success  = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_ADDR;
            S_ADDR: begin
                transaction   = 2'b01;
                token_pkt_out = {PID_OUT, ADDR, ENDP_ADDR};
                data_pkt_out  = {PID_DATA, rev({page_addr, {(DW-16){1'b0}}})};
                if (ptcl_done) begin
                    if (ptcl_success) state_nxt = is_read ? S_DATA : S_WLOAD;
                    else              state_nxt = retry_left ? S_RETRY : S_FAIL;
                end
            end
            S_WLOAD: begin
                data_req = 1'b1;
                if (data_in_valid) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (is_read) begin
                    transaction   = 2'b10;
                    token_pkt_out = {PID_IN, ADDR, ENDP_DATA};
                end else begin
                    transaction   = 2'b01;
                    token_pkt_out = {PID_OUT, ADDR, ENDP_DATA};
                    data_pkt_out  = {PID_DATA, rev(wbuf)};
                end
                if (ptcl_done) begin
                    if (ptcl_success) state_nxt = last_page ? S_OK : S_ADDR;
                    else              state_nxt = retry_left ? S_RETRY : S_FAIL;
                end
            end
            S_RETRY: state_nxt = retry_data ? S_DATA : S_ADDR;
            S_OK: begin
                task_done    = 1'b1;
                task_success = 1'b1;
                if (tsk == 2'b00) state_nxt = S_IDLE;
            end
            S_FAIL: begin
                task_done = 1'b1;
                if (tsk == 2'b00) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_usb_rw_burst_ctrl.sv
// Directed bench for usb_rw_burst_ctrl: a vector table of whole tasks driven through a
// scripted protocol responder, plus a hand-written mid-burst reset sequence.
module tb_usb_rw_burst_ctrl;
    logic        clk = 1'b0;
    logic        rst_b;
    logic [1:0]  tsk;
    logic [15:0] mempage;
    logic [3:0]  burst_len;
    logic [63:0] data_in;
    logic        data_in_valid;
    logic        data_req;
    logic [63:0] data_to_tb;
    logic        data_avail;
    logic [18:0] token_pkt_out;
    logic [71:0] data_pkt_out;
    logic [1:0]  transaction;
    logic        ptcl_done;
    logic        ptcl_success;
    logic [63:0] ptcl_data;
    logic        task_done;
    logic        task_success;
    logic [3:0]  pages_done;

    int n_total = 0;
    int n_pass  = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [1:0]  tsk;
        logic [15:0] page;
        logic [3:0]  len;
        logic [63:0] wbase;
        int          addr_fails;
        int          data_fails;
        int          stall;
        logic        exp_ok;
        logic [3:0]  exp_pages;
        int          exp_gaps;
        int          exp_reqs;
        int          exp_avail;
    } vec_t;

    vec_t vecs[6];
    vec_t rv, pv;
    bit   ab;

    usb_rw_burst_ctrl dut (
        .clk(clk), .rst_b(rst_b), .tsk(tsk), .mempage(mempage), .burst_len(burst_len),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_req(data_req),
        .data_to_tb(data_to_tb), .data_avail(data_avail), .token_pkt_out(token_pkt_out),
        .data_pkt_out(data_pkt_out), .transaction(transaction), .ptcl_done(ptcl_done),
        .ptcl_success(ptcl_success), .ptcl_data(ptcl_data), .task_done(task_done),
        .task_success(task_success), .pages_done(pages_done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rev64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = v[63-i];
        return r;
    endfunction

    function automatic logic [63:0] rd_word(input int k);
        return 64'h0F1E2D3C4B5A6978 + 64'(k) * 64'h0101010101010101;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_transaction"}, transaction, 0);
        check({tag, "_token"}, token_pkt_out, 0);
        check({tag, "_data_pkt"}, data_pkt_out, 0);
        check({tag, "_data_to_tb"}, data_to_tb, 0);
        check({tag, "_data_avail"}, data_avail, 0);
        check({tag, "_data_req"}, data_req, 0);
        check({tag, "_task_done"}, task_done, 0);
        check({tag, "_task_success"}, task_success, 0);
        check({tag, "_pages_done"}, pages_done, 0);
    endtask

    // Drives one task and plays the protocol FSM; abort_in>0 stops before answering that IN.
    task automatic run_vec(input vec_t v, input int abort_in, output bit aborted);
        int k, phase, af, dfl, stall_left, reqs, gaps, avails, stall_bad, in_seen;
        bit started, req_prev, done_seen, fail_now, rd;
        logic got_ok;
        logic [3:0] got_pages;
        logic [15:0] pg;
        logic [1:0] etx;
        logic [18:0] etok;
        logic [71:0] epkt;
        k = 0; phase = 0; af = v.addr_fails; dfl = v.data_fails; stall_left = v.stall;
        reqs = 0; gaps = 0; avails = 0; stall_bad = 0; in_seen = 0;
        started = 0; req_prev = 0; done_seen = 0; aborted = 0;
        got_ok = 0; got_pages = 0;
        rd = (v.tsk == 2'b01);
        exp_q.delete();
        tsk = v.tsk; mempage = v.page; burst_len = v.len;
        for (int cyc = 0; cyc < 400 && !done_seen && !aborted; cyc++) begin
            @(negedge clk);
            if (cyc == 0) check("start_latency", transaction, 2'b01);
            if (data_avail) begin
                avails++;
                if (exp_q.size() > 0) check("read_word", data_to_tb, exp_q.pop_front());
                else check("spurious_avail", data_avail, 0);
            end
            if (task_done) begin
                done_seen = 1;
                got_ok = task_success;
                got_pages = pages_done;
            end else begin
                if (data_req) begin
                    if (!req_prev) reqs++;
                    if (stall_left > 0) begin
                        stall_left--;
                        if (transaction != 2'b00) stall_bad++;
                        data_in_valid = 1'b0;
                    end else begin
                        data_in = v.wbase + 64'(k);
                        data_in_valid = 1'b1;
                    end
                end else begin
                    data_in_valid = 1'b0;
                end
                req_prev = data_req;
                if (transaction != 2'b00) started = 1;
                else if (started && !data_req) gaps++;
                if (ptcl_done) begin
                    ptcl_done = 1'b0;
                end else if (transaction != 2'b00) begin
                    if (transaction == 2'b10) in_seen++;
                    if (abort_in > 0 && in_seen == abort_in) begin
                        aborted = 1;
                    end else begin
                        pg = v.page + 16'(k);
                        if (phase == 0) begin
                            etx = 2'b01; etok = {8'h87, 7'h50, 4'h2};
                            epkt = {8'hC3, rev64({pg, 48'h0})};
                        end else if (rd) begin
                            etx = 2'b10; etok = {8'h96, 7'h50, 4'h1}; epkt = '0;
                        end else begin
                            etx = 2'b01; etok = {8'h87, 7'h50, 4'h1};
                            epkt = {8'hC3, rev64(v.wbase + 64'(k))};
                        end
                        check(phase == 0 ? "addr_transaction" : "data_transaction", transaction, etx);
                        check(phase == 0 ? "addr_token" : "data_token", token_pkt_out, etok);
                        check(phase == 0 ? "addr_packet" : "data_packet", data_pkt_out, epkt);
                        fail_now = 0;
                        if (k == 0 && phase == 0 && af > 0) begin fail_now = 1; af--; end
                        if (k == 0 && phase == 1 && dfl > 0) begin fail_now = 1; dfl--; end
                        ptcl_success = !fail_now;
                        ptcl_done = 1'b1;
                        if (!fail_now) begin
                            if (phase == 1 && rd) begin
                                ptcl_data = rd_word(k);
                                exp_q.push_back(rev64(rd_word(k)));
                            end
                            if (phase == 0) phase = 1;
                            else begin phase = 0; k++; end
                        end
                    end
                end
            end
        end
        if (!aborted) begin
            check("task_done_timeout", done_seen, 1);
            if (done_seen) begin
                check("task_success", got_ok, v.exp_ok);
                check("pages_done", got_pages, v.exp_pages);
                check("data_req_count", reqs, v.exp_reqs);
                check("retry_gaps", gaps, v.exp_gaps);
                check("data_avail_count", avails, v.exp_avail);
                check("stall_violations", stall_bad, 0);
                check("pending_reads", exp_q.size(), 0);
                tsk = 2'b00;
                data_in_valid = 1'b0;
                @(negedge clk);
                check("release_task_done", task_done, 0);
                check("release_pages_done", pages_done, 0);
                check("release_transaction", transaction, 0);
            end
        end
    endtask

    initial begin
        rst_b = 1'b0; tsk = 2'b00; mempage = '0; burst_len = '0;
        data_in = '0; data_in_valid = 1'b0;
        ptcl_done = 1'b0; ptcl_success = 1'b0; ptcl_data = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_b = 1'b1;
        @(negedge clk);
        check_zero_outputs("idle");

        vecs[0] = '{2'b10, 16'h1234, 4'd1, 64'h0123456789ABCDEF, 0, 0, 0,  1'b1, 4'd1, 0, 1, 0};
        vecs[1] = '{2'b01, 16'hFFFF, 4'd3, 64'h0,                0, 0, 0,  1'b1, 4'd3, 0, 0, 3};
        vecs[2] = '{2'b10, 16'h0042, 4'd1, 64'h1122334455667788, 0, 2, 0,  1'b1, 4'd1, 2, 1, 0};
        vecs[3] = '{2'b01, 16'h0010, 4'd2, 64'h0,                4, 0, 0,  1'b0, 4'd0, 3, 0, 0};
        vecs[4] = '{2'b10, 16'h7000, 4'd0, 64'hFEDCBA9876543210, 0, 0, 10, 1'b1, 4'd1, 0, 1, 0};
        vecs[5] = '{2'b10, 16'h00AA, 4'd2, 64'hA0A0B0B0C0C0D0D0, 3, 0, 0,  1'b1, 4'd2, 3, 2, 0};
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], 0, ab);
            @(negedge clk);
        end

        rv = '{2'b01, 16'h0100, 4'd3, 64'h0, 0, 0, 0, 1'b1, 4'd3, 0, 0, 3};
        run_vec(rv, 2, ab);
        check("reset_reached_second_in", ab, 1);
        rst_b = 1'b0;
        #1;
        check_zero_outputs("midreset");
        tsk = 2'b00;
        data_in_valid = 1'b0;
        ptcl_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check_zero_outputs("post_reset");
        pv = '{2'b01, 16'hABCD, 4'd2, 64'h0, 0, 0, 0, 1'b1, 4'd2, 0, 0, 2};
        run_vec(pv, 0, ab);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
